axi_slice128: RTL and testbench
===============================

AXI_SLICE128 -- requirements
Module: axi_slice128

Interface
REQ-001 SHALL have parameter ADDR_W, default 40, address width of AR/AW payload.
REQ-002 SHALL have parameter ID_W, default 8, width of all ID fields.
REQ-003 SHALL have port pll_core_cpuclk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port pad_cpu_rst, input, 1: synchronous active-high reset.
REQ-005 SHALL have AR channel in: arvalid_m, araddr_m[ADDR_W], arid_m[ID_W], arlen_m[8], arsize_m[3], arburst_m[2], arcache_m[4], arprot_m[3] inputs, arready_m output.
REQ-006 SHALL have AW channel in: the same field set with aw prefix and _m suffix; awready_m output.
REQ-007 SHALL have W channel in: wvalid_m, wdata_m[128], wstrb_m[16], wid_m[ID_W], wlast_m inputs; wready_m output.
REQ-008 SHALL have R channel out to upstream: rvalid_m, rdata_m[128], rid_m[ID_W], rresp_m[2], rlast_m outputs; rready_m input.
REQ-009 SHALL have B channel out to upstream: bvalid_m, bid_m[ID_W], bresp_m[2] outputs; bready_m input.
REQ-010 SHALL have a downstream AR/AW/W master port mirroring REQ-005..007 with _s0 suffix, directions inverted, for direct connection to the 128-bit SRAM slave.
REQ-011 SHALL have a downstream R/B slave port mirroring REQ-008..009 with _s0 suffix, directions inverted.

Function
REQ-012 SHALL place one independent full register slice on each of AR, AW, W (upstream to downstream) and R, B (downstream to upstream).
REQ-013 Each slice SHALL be a 2-entry buffer with an occupancy counter cnt in 0..2.
REQ-014 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-015 in_ready SHALL be a flop output, equal to (cnt<2) as computed for the next cycle; no combinational path from out_ready to in_ready.
REQ-016 out_valid SHALL be a flop output, equal to (cnt!=0); out payload SHALL come directly from the head register.
REQ-017 Latency: a beat accepted in cycle N SHALL appear at the output with valid high in cycle N+1 when the slice was empty.
REQ-018 Throughput: with out_ready held high, a slice SHALL sustain one beat per cycle indefinitely.
REQ-019 Push only: cnt+1. Pop only: cnt-1. Push and pop together at cnt=1: cnt stays 1, new beat becomes head on the next cycle.
REQ-020 Push and pop together at cnt=0 SHALL NOT occur, since out_valid is 0.
REQ-021 Push at cnt=2 SHALL NOT occur, since in_ready is 0.
REQ-022 Beat order SHALL be preserved per channel.
REQ-023 Payload SHALL be forwarded bit-exact: no address, ID, len, strb or last modification.
REQ-024 out_valid SHALL stay high and payload SHALL stay stable until popped (AXI stability rule).
REQ-025 Channels SHALL be fully independent; stall on one channel SHALL NOT affect another.
REQ-026 Ordering between AR and AW SHALL NOT be imposed; the downstream slave resolves it.

Reset
REQ-027 While pad_cpu_rst=1 at a clock edge: all cnt SHALL become 0; all out_valid (arvalid_s0, awvalid_s0, wvalid_s0, rvalid_m, bvalid_m) SHALL become 0; all in_ready SHALL become 0; all payload registers SHALL become 0.
REQ-028 On the first edge with pad_cpu_rst=0, all in_ready SHALL become 1.
REQ-029 Reset asserted mid-burst SHALL discard buffered beats; no partial beat SHALL be emitted after reset.

Verification
REQ-030 AR single beat: arvalid_m=1, araddr_m=40'h0000001230, arlen_m=0, arid_m=8'h5 at cycle N -> arvalid_s0=1 with identical fields at N+1; arready_m stays 1.
REQ-031 Backpressure fill: W stream of 4 beats (wdata 1..4), wready_s0=0 -> wready_m falls after 2 beats accepted; on release, downstream sees 1,2,3,4 in order, wlast only on beat 4.
REQ-032 Full throughput: 16-beat R burst (arlen=15) with rready_m=1 constantly -> rvalid_m high 16 consecutive cycles, rlast_m on the 16th beat only, rid_m constant.
REQ-033 Simultaneous push/pop at cnt=1 on B: bvalid_s0 and bready_m both high for 3 cycles -> cnt stays 1; bid sequence preserved; bready_s0 never drops.
REQ-034 Reset mid-burst: assert pad_cpu_rst for 1 cycle while AW, W and R slices hold 2 beats each -> next cycle all valids are 0 and all readys are 0; the following cycle all readys are 1; no stale beat emitted.
REQ-035 Random valid/ready on all five channels for 10k cycles against a scoreboard -> zero lost, duplicated or reordered beats; no valid deassertion without a handshake.

Source files
------------

// File: rtl/axi_slice128_if.sv
// AXI 128-bit bus bundle: AR, AW, W request channels and R, B response channels.
// master modport drives requests and accepts responses; slave modport is the mirror.
interface axi_slice128_if #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned ID_W   = 8
);
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arready;

  logic              awvalid;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awready;

  logic              wvalid;
  logic [127:0]      wdata;
  logic [15:0]       wstrb;
  logic [ID_W-1:0]   wid;
  logic              wlast;
  logic              wready;

  logic              rvalid;
  logic [127:0]      rdata;
  logic [ID_W-1:0]   rid;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rready;

  logic              bvalid;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bready;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, arcache, arprot,
    input  arready,
    output awvalid, awaddr, awid, awlen, awsize, awburst, awcache, awprot,
    input  awready,
    output wvalid, wdata, wstrb, wid, wlast,
    input  wready,
    input  rvalid, rdata, rid, rresp, rlast,
    output rready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, arcache, arprot,
    output arready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst, awcache, awprot,
    output awready,
    input  wvalid, wdata, wstrb, wid, wlast,
    output wready,
    output rvalid, rdata, rid, rresp, rlast,
    input  rready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi_slice128.sv
// Full register slice on all five AXI channels between an upstream master and
// the 128-bit SRAM slave.
// Ports:
//   pll_core_cpuclk - clock, all state on rising edge
//   pad_cpu_rst     - synchronous active-high reset
//   m               - upstream bus (slave modport): AR/AW/W in, R/B out
//   s0              - downstream bus (master modport): AR/AW/W out, R/B in

// 2-entry fully registered slice: in_ready and out_valid are both flops, so no
// combinational path crosses the slice in either direction.
module axi_slice128_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              pll_core_cpuclk,
  input  logic              pad_cpu_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              push, pop;

  // Next-state: occupancy, head/tail payload and the registered handshakes.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    push   = in_valid && in_ready_q;
    pop    = out_valid_q && out_ready;
    unique case ({push, pop})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) head_d = in_data;
        else               tail_d = in_data;
      end
      2'b01: begin
        cnt_d  = cnt_q - 2'd1;
        head_d = tail_q;
      end
      // Only reachable at cnt=1: the new beat replaces the departing head.
      2'b11: head_d = in_data;
      default: ;
    endcase
    in_ready_d  = (cnt_d != 2'd2);
    out_valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge pll_core_cpuclk) begin
    if (pad_cpu_rst) begin
      cnt_q       <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;
endmodule

module axi_slice128 #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned ID_W   = 8
) (
  input logic            pll_core_cpuclk,
  input logic            pad_cpu_rst,
  axi_slice128_if.slave  m,
  axi_slice128_if.master s0
);
  localparam int unsigned AX_W = ADDR_W + ID_W + 8 + 3 + 2 + 4 + 3;
  localparam int unsigned WD_W = 128 + 16 + ID_W + 1;
  localparam int unsigned RD_W = 128 + ID_W + 2 + 1;
  localparam int unsigned BR_W = ID_W + 2;

  logic [AX_W-1:0] ar_in, ar_out, aw_in, aw_out;
  logic [WD_W-1:0] w_in, w_out;
  logic [RD_W-1:0] r_in, r_out;
  logic [BR_W-1:0] b_in, b_out;

  // Payloads travel as flat vectors; fields are reassembled unchanged.
  assign ar_in = {m.araddr, m.arid, m.arlen, m.arsize, m.arburst, m.arcache, m.arprot};
  assign {s0.araddr, s0.arid, s0.arlen, s0.arsize, s0.arburst, s0.arcache, s0.arprot} = ar_out;
  assign aw_in = {m.awaddr, m.awid, m.awlen, m.awsize, m.awburst, m.awcache, m.awprot};
  assign {s0.awaddr, s0.awid, s0.awlen, s0.awsize, s0.awburst, s0.awcache, s0.awprot} = aw_out;
  assign w_in  = {m.wdata, m.wstrb, m.wid, m.wlast};
  assign {s0.wdata, s0.wstrb, s0.wid, s0.wlast} = w_out;
  assign r_in  = {s0.rdata, s0.rid, s0.rresp, s0.rlast};
  assign {m.rdata, m.rid, m.rresp, m.rlast} = r_out;
  assign b_in  = {s0.bid, s0.bresp};
  assign {m.bid, m.bresp} = b_out;

  axi_slice128_reg #(.DATA_W(AX_W)) u_ar (
    .pll_core_cpuclk(pll_core_cpuclk), .pad_cpu_rst(pad_cpu_rst),
    .in_valid(m.arvalid), .in_ready(m.arready), .in_data(ar_in),
    .out_valid(s0.arvalid), .out_ready(s0.arready), .out_data(ar_out)
  );

  axi_slice128_reg #(.DATA_W(AX_W)) u_aw (
    .pll_core_cpuclk(pll_core_cpuclk), .pad_cpu_rst(pad_cpu_rst),
    .in_valid(m.awvalid), .in_ready(m.awready), .in_data(aw_in),
    .out_valid(s0.awvalid), .out_ready(s0.awready), .out_data(aw_out)
  );

  axi_slice128_reg #(.DATA_W(WD_W)) u_w (
    .pll_core_cpuclk(pll_core_cpuclk), .pad_cpu_rst(pad_cpu_rst),
    .in_valid(m.wvalid), .in_ready(m.wready), .in_data(w_in),
    .out_valid(s0.wvalid), .out_ready(s0.wready), .out_data(w_out)
  );

  axi_slice128_reg #(.DATA_W(RD_W)) u_r (
    .pll_core_cpuclk(pll_core_cpuclk), .pad_cpu_rst(pad_cpu_rst),
    .in_valid(s0.rvalid), .in_ready(s0.rready), .in_data(r_in),
    .out_valid(m.rvalid), .out_ready(m.rready), .out_data(r_out)
  );

  axi_slice128_reg #(.DATA_W(BR_W)) u_b (
    .pll_core_cpuclk(pll_core_cpuclk), .pad_cpu_rst(pad_cpu_rst),
    .in_valid(s0.bvalid), .in_ready(s0.bready), .in_data(b_in),
    .out_valid(m.bvalid), .out_ready(m.bready), .out_data(b_out)
  );
endmodule

// File: tb/tb_axi_slice128.sv
// Self-checking bench for axi_slice128: directed vector table on AR, hand
// sequences for W backpressure, R burst, B push/pop, mid-burst reset, and a
// random valid/ready run on all channels against per-channel queues.
module tb_axi_slice128;
  localparam int unsigned NCH = 5;   // 0 AR, 1 AW, 2 W, 3 R, 4 B
  localparam int unsigned PW  = 161; // bit 160 = last, low bits = packed fields
  typedef logic [PW-1:0] beat_t;

  typedef struct {
    logic  iv;
    beat_t b;
    logic  ordy;
    logic  exp_ir;
    logic  exp_ov;
    beat_t exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_slice128_if #(.ADDR_W(40), .ID_W(8)) bus_m ();
  axi_slice128_if #(.ADDR_W(40), .ID_W(8)) bus_s0 ();

  axi_slice128 #(.ADDR_W(40), .ID_W(8)) dut (
    .pll_core_cpuclk(clk),
    .pad_cpu_rst(rst),
    .m(bus_m),
    .s0(bus_s0)
  );

  logic  drv_valid[NCH];
  beat_t drv_beat[NCH];
  logic  drv_ready[NCH];
  logic  obs_in_ready[NCH];
  logic  obs_out_valid[NCH];
  beat_t obs_beat[NCH];

  always_comb begin
    bus_m.arvalid = drv_valid[0];
    {bus_m.arprot, bus_m.arcache, bus_m.arburst, bus_m.arsize, bus_m.arlen, bus_m.arid, bus_m.araddr} = drv_beat[0][67:0];
    bus_m.awvalid = drv_valid[1];
    {bus_m.awprot, bus_m.awcache, bus_m.awburst, bus_m.awsize, bus_m.awlen, bus_m.awid, bus_m.awaddr} = drv_beat[1][67:0];
    bus_m.wvalid = drv_valid[2];
    {bus_m.wid, bus_m.wstrb, bus_m.wdata} = drv_beat[2][151:0];
    bus_m.wlast = drv_beat[2][160];
    bus_s0.rvalid = drv_valid[3];
    {bus_s0.rresp, bus_s0.rid, bus_s0.rdata} = drv_beat[3][137:0];
    bus_s0.rlast = drv_beat[3][160];
    bus_s0.bvalid = drv_valid[4];
    {bus_s0.bresp, bus_s0.bid} = drv_beat[4][9:0];
    bus_s0.arready = drv_ready[0];
    bus_s0.awready = drv_ready[1];
    bus_s0.wready  = drv_ready[2];
    bus_m.rready   = drv_ready[3];
    bus_m.bready   = drv_ready[4];
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) obs_beat[c] = '0;
    obs_in_ready[0]  = bus_m.arready;
    obs_in_ready[1]  = bus_m.awready;
    obs_in_ready[2]  = bus_m.wready;
    obs_in_ready[3]  = bus_s0.rready;
    obs_in_ready[4]  = bus_s0.bready;
    obs_out_valid[0] = bus_s0.arvalid;
    obs_out_valid[1] = bus_s0.awvalid;
    obs_out_valid[2] = bus_s0.wvalid;
    obs_out_valid[3] = bus_m.rvalid;
    obs_out_valid[4] = bus_m.bvalid;
    obs_beat[0][67:0]   = {bus_s0.arprot, bus_s0.arcache, bus_s0.arburst, bus_s0.arsize, bus_s0.arlen, bus_s0.arid, bus_s0.araddr};
    obs_beat[1][67:0]   = {bus_s0.awprot, bus_s0.awcache, bus_s0.awburst, bus_s0.awsize, bus_s0.awlen, bus_s0.awid, bus_s0.awaddr};
    obs_beat[2][151:0]  = {bus_s0.wid, bus_s0.wstrb, bus_s0.wdata};
    obs_beat[2][160]    = bus_s0.wlast;
    obs_beat[3][137:0]  = {bus_m.rresp, bus_m.rid, bus_m.rdata};
    obs_beat[3][160]    = bus_m.rlast;
    obs_beat[4][9:0]    = {bus_m.bresp, bus_m.bid};
  end

  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t sb_q[NCH][$];
  logic  held_v[NCH];
  beat_t held_b[NCH];
  logic  fired_in[NCH];
  logic  fired_out[NCH];
  beat_t out_b[NCH];

  task automatic chk(input string name, input beat_t act, input beat_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic beat_t mask_of(input int c);
    beat_t one = beat_t'(1);
    case (c)
      0, 1:    return (one << 68) - one;
      2:       return ((one << 152) - one) | (one << 160);
      3:       return ((one << 138) - one) | (one << 160);
      default: return (one << 10) - one;
    endcase
  endfunction

  function automatic beat_t rand_beat(input int c);
    beat_t b;
    b = beat_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    return b & mask_of(c);
  endfunction

  function automatic beat_t ax_beat(input logic [39:0] addr, input logic [7:0] id, input logic [7:0] len);
    return beat_t'({3'd2, 4'd3, 2'd1, 3'd4, len, id, addr});
  endfunction

  function automatic beat_t w_beat(input int i);
    beat_t b = '0;
    b[127:0]   = 128'(i);
    b[143:128] = 16'hFFFF;
    b[151:144] = 8'h03;
    b[160]     = (i == 4);
    return b;
  endfunction

  function automatic beat_t r_beat(input int i);
    beat_t b = '0;
    b[127:0]   = 128'h1234_5678_0000 + 128'(i);
    b[135:128] = 8'h7C;
    b[160]     = (i == 15);
    return b;
  endfunction

  function automatic beat_t b_beat(input int i);
    beat_t b = '0;
    b[7:0] = 8'(i);
    b[9:8] = 2'b01;
    return b;
  endfunction

  // One clock with inputs already set; scoreboard, stability and handshake capture.
  task automatic step();
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (held_v[c]) begin
        chk($sformatf("stable_valid ch%0d", c), beat_t'(obs_out_valid[c]), beat_t'(1'b1));
        chk($sformatf("stable_payload ch%0d", c), obs_beat[c], held_b[c]);
      end
      fired_in[c]  = drv_valid[c] && obs_in_ready[c];
      fired_out[c] = obs_out_valid[c] && drv_ready[c];
      out_b[c]     = obs_beat[c];
      if (fired_in[c]) sb_q[c].push_back(drv_beat[c]);
      if (fired_out[c]) begin
        if (sb_q[c].size() == 0) begin
          chk($sformatf("sb_spurious ch%0d", c), beat_t'(sb_q[c].size()), beat_t'(1));
        end else begin
          chk($sformatf("sb_order ch%0d", c), obs_beat[c], sb_q[c].pop_front());
        end
      end
      held_v[c] = obs_out_valid[c] && !drv_ready[c];
      held_b[c] = obs_beat[c];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_sb();
    for (int c = 0; c < NCH; c++) begin
      sb_q[c].delete();
      held_v[c] = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    beat_t got[$];
    int idx, first_c, last_c, cyc, gaps;
    beat_t a1, a2, a3, a4;

    for (int c = 0; c < NCH; c++) begin
      drv_valid[c] = 1'b0;
      drv_beat[c]  = '0;
      drv_ready[c] = 1'b0;
      held_v[c]    = 1'b0;
    end

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("rst in_ready ch%0d", c), beat_t'(obs_in_ready[c]), beat_t'(1'b0));
      chk($sformatf("rst out_valid ch%0d", c), beat_t'(obs_out_valid[c]), beat_t'(1'b0));
      chk($sformatf("rst payload ch%0d", c), obs_beat[c], beat_t'(0));
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("post_rst in_ready ch%0d", c), beat_t'(obs_in_ready[c]), beat_t'(1'b1));

    // AR vector table: fill, full stall, pop, push+pop at cnt=1, drain.
    a1 = ax_beat(40'h00_0000_1230, 8'h05, 8'd0);
    a2 = ax_beat(40'hFF_FFFF_FFF0, 8'hAA, 8'd15);
    a3 = ax_beat(40'h80_0000_0000, 8'hFF, 8'd255);
    a4 = ax_beat(40'h00_0000_0001, 8'h00, 8'd1);
    vt[0] = '{1'b1, a1, 1'b0, 1'b1, 1'b1, a1};
    vt[1] = '{1'b1, a2, 1'b0, 1'b0, 1'b1, a1};
    vt[2] = '{1'b1, a3, 1'b0, 1'b0, 1'b1, a1};
    vt[3] = '{1'b1, a3, 1'b1, 1'b1, 1'b1, a2};
    vt[4] = '{1'b1, a3, 1'b1, 1'b1, 1'b1, a3};
    vt[5] = '{1'b0, a3, 1'b1, 1'b1, 1'b0, a3};
    vt[6] = '{1'b1, a4, 1'b1, 1'b1, 1'b1, a4};
    vt[7] = '{1'b0, a4, 1'b0, 1'b1, 1'b1, a4};
    vt[8] = '{1'b0, a4, 1'b1, 1'b1, 1'b0, a4};
    for (int i = 0; i < 9; i++) begin
      drv_valid[0] = vt[i].iv;
      drv_beat[0]  = vt[i].b;
      drv_ready[0] = vt[i].ordy;
      step();
      chk($sformatf("ar_vec%0d arready", i), beat_t'(obs_in_ready[0]), beat_t'(vt[i].exp_ir));
      chk($sformatf("ar_vec%0d arvalid_s0", i), beat_t'(obs_out_valid[0]), beat_t'(vt[i].exp_ov));
      if (vt[i].exp_ov) chk($sformatf("ar_vec%0d payload", i), obs_beat[0], vt[i].exp_b);
    end
    drv_valid[0] = 1'b0;

    // W backpressure: two beats fill the slice, third stalls, then release.
    drv_ready[2] = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drv_valid[2] = 1'b1;
      drv_beat[2]  = w_beat(i);
      step();
      chk($sformatf("w_fill%0d wready_m", i), beat_t'(obs_in_ready[2]), beat_t'(i == 1));
      chk($sformatf("w_fill%0d head", i), obs_beat[2], w_beat(1));
    end
    idx = 3;
    drv_ready[2] = 1'b1;
    for (int k = 0; k < 20 && got.size() < 4; k++) begin
      drv_valid[2] = (idx <= 4);
      drv_beat[2]  = (idx <= 4) ? w_beat(idx) : '0;
      step();
      if (fired_in[2]) idx++;
      if (fired_out[2]) got.push_back(out_b[2]);
    end
    chk("w_release beats", beat_t'(got.size()), beat_t'(4));
    for (int i = 0; i < got.size(); i++) chk($sformatf("w_release beat%0d", i + 1), got[i], w_beat(i + 1));
    drv_valid[2] = 1'b0;
    got.delete();

    // R 16-beat burst at full throughput.
    drv_ready[3] = 1'b1;
    idx = 0; first_c = -1; last_c = -1; gaps = 0; cyc = 0;
    for (int k = 0; k < 40 && got.size() < 16; k++) begin
      drv_valid[3] = (idx < 16);
      drv_beat[3]  = (idx < 16) ? r_beat(idx) : '0;
      if (idx < 16 && !obs_in_ready[3]) gaps++;
      step();
      if (fired_in[3]) idx++;
      if (fired_out[3]) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        got.push_back(out_b[3]);
      end
      cyc++;
    end
    chk("r_burst beats", beat_t'(got.size()), beat_t'(16));
    chk("r_burst consecutive", beat_t'(last_c - first_c), beat_t'(15));
    chk("r_burst rready_s0 drops", beat_t'(gaps), beat_t'(0));
    for (int i = 0; i < got.size(); i++) chk($sformatf("r_burst beat%0d", i), got[i], r_beat(i));
    drv_valid[3] = 1'b0;
    got.delete();

    // B: push and pop together at cnt=1 for consecutive cycles.
    drv_ready[4] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drv_valid[4] = (i <= 3);
      drv_beat[4]  = (i <= 3) ? b_beat(i) : '0;
      step();
      chk($sformatf("b_pp%0d bready_s0", i), beat_t'(obs_in_ready[4]), beat_t'(1'b1));
      chk($sformatf("b_pp%0d bvalid_m", i), beat_t'(obs_out_valid[4]), beat_t'(i <= 3));
      if (i <= 3) chk($sformatf("b_pp%0d bid", i), obs_beat[4], b_beat(i));
    end

    // Reset with AW, W, R each holding two beats.
    for (int c = 0; c < NCH; c++) drv_ready[c] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv_valid[1] = 1'b1; drv_beat[1] = ax_beat(40'h10 + 40'(i), 8'h40, 8'd3);
      drv_valid[2] = 1'b1; drv_beat[2] = w_beat(i + 1);
      drv_valid[3] = 1'b1; drv_beat[3] = r_beat(i);
      step();
    end
    chk("pre_rst awready full", beat_t'(obs_in_ready[1]), beat_t'(1'b0));
    chk("pre_rst wready full", beat_t'(obs_in_ready[2]), beat_t'(1'b0));
    chk("pre_rst rready_s0 full", beat_t'(obs_in_ready[3]), beat_t'(1'b0));
    for (int c = 0; c < NCH; c++) drv_valid[c] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_sb();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("mid_rst valid ch%0d", c), beat_t'(obs_out_valid[c]), beat_t'(1'b0));
      chk($sformatf("mid_rst ready ch%0d", c), beat_t'(obs_in_ready[c]), beat_t'(1'b0));
    end
    @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("after_rst ready ch%0d", c), beat_t'(obs_in_ready[c]), beat_t'(1'b1));
      drv_ready[c] = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      step();
      for (int c = 0; c < NCH; c++)
        chk($sformatf("stale k%0d ch%0d", k, c), beat_t'(obs_out_valid[c]), beat_t'(1'b0));
    end

    // Random valid/ready on all channels; the scoreboard in step() checks order.
    for (int k = 0; k < 10000; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!drv_valid[c] || fired_in[c]) begin
          drv_valid[c] = 1'($urandom_range(0, 1));
          drv_beat[c]  = rand_beat(c);
        end
        drv_ready[c] = 1'($urandom_range(0, 1));
      end
      step();
    end
    // Drain: keep pending beats until accepted, then let everything empty out.
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < NCH; c++) begin
        if (fired_in[c]) drv_valid[c] = 1'b0;
        drv_ready[c] = 1'b1;
      end
      step();
    end
    for (int c = 0; c < NCH; c++)
      chk($sformatf("drain lost ch%0d", c), beat_t'(sb_q[c].size()), beat_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
